// File: rtl/booth_r4_seq_mul.sv
// Sequential radix-4 Booth multiplier: one recoded multiplier digit per clock, start/done handshake.
// Optional build macro BOOTH_EARLY_EXIT_EN finishes as soon as all remaining digits are zero.
module booth_r4_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z
);

  localparam int E  = WIDTH + 2;
  localparam int N  = E / 2;
  localparam int AW = 2 * WIDTH + 4;
  localparam int KW = $clog2(N + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_r;
  logic [E:0]      a_sh_r;    // {a_e, 1'b0}, shifted right two bits per step
  logic [AW-1:0]   bm_r;      // extended multiplicand, pre-shifted by 2k
  logic [AW-1:0]   acc_r;
  logic [KW-1:0]   k_r;

  logic [2:0]      triple_s;
  logic [AW-1:0]   pp_s;
  logic [AW-1:0]   acc_next_s;
  logic            last_s;
  logic            finish_s;
  logic [E-1:0]    a_ext_s;
  logic [AW-1:0]   b_ext_s;

  // Operand extension for the accept edge.
  always_comb begin
    a_ext_s = '0;
    b_ext_s = '0;
    if (is_signed) begin
      a_ext_s = {{2{a[WIDTH-1]}}, a};
      b_ext_s = {{(AW-WIDTH){b[WIDTH-1]}}, b};
    end else begin
      a_ext_s = {2'b00, a};
      b_ext_s = {{(AW-WIDTH){1'b0}}, b};
    end
  end

  // Booth digit recoding and accumulation for the current step.
  always_comb begin
    triple_s = a_sh_r[2:0];
    pp_s     = '0;
    case (triple_s)
      3'b000, 3'b111: pp_s = '0;
      3'b001, 3'b010: pp_s = bm_r;
      3'b011:         pp_s = bm_r << 1;
      3'b100:         pp_s = -(bm_r << 1);
      3'b101, 3'b110: pp_s = -bm_r;
      default:        pp_s = '0;
    endcase
    acc_next_s = acc_r + pp_s;
    last_s     = (k_r == KW'(N - 1));
`ifdef BOOTH_EARLY_EXIT_EN
    // Remaining multiplier bits all equal means every later digit recodes to zero.
    finish_s = last_s | (&a_sh_r[E:2]) | ~(|a_sh_r[E:2]);
`else
    finish_s = last_s;
`endif
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r <= IDLE;
      a_sh_r  <= '0;
      bm_r    <= '0;
      acc_r   <= '0;
      k_r     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      z       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh_r  <= {a_ext_s, 1'b0};
            bm_r    <= b_ext_s;
            acc_r   <= '0;
            k_r     <= '0;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          acc_r  <= acc_next_s;
          a_sh_r <= {a_sh_r[E], a_sh_r[E], a_sh_r[E:2]};
          bm_r   <= bm_r << 2;
          k_r    <= k_r + KW'(1);
          if (finish_s) begin
            z       <= acc_next_s[2*WIDTH-1:0];
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= IDLE;
          end else begin
            busy    <= 1'b1;
            done    <= 1'b0;
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
